// File: rtl/scan_display_driver_if.sv
// Port bundle for scan_display_driver: scan control and packed digit inputs, plus
// the registered segment/digit-enable outputs and the frame pulse.
interface scan_display_driver_if #(
  parameter int unsigned N_DIGITS = 4
);
  logic                    en;
  logic [4*N_DIGITS-1:0]   digits_in;
  logic [N_DIGITS-1:0]     dp_in;
  logic                    lz_en;
  logic [7:0]              seg_out;
  logic [N_DIGITS-1:0]     dig_sel;
  logic                    frame_done;

  modport master (
    output en, digits_in, dp_in, lz_en,
    input  seg_out, dig_sel, frame_done
  );

  modport slave (
    input  en, digits_in, dp_in, lz_en,
    output seg_out, dig_sel, frame_done
  );
endinterface

// File: rtl/scan_display_driver.sv
// Time-multiplexed seven-segment driver: one digit per slot, blanking at the start
// of each slot, frame-wide input snapshot, optional hex decode and leading-zero blanking.
module scan_display_driver #(
  parameter int unsigned N_DIGITS     = 4,
  parameter int unsigned CLK_DIV      = 1000,
  parameter int unsigned BLANK_CYCLES = 2,
  parameter bit          HEX_EN       = 1'b1
) (
  input logic                  clk,
  input logic                  rst,
  scan_display_driver_if.slave bus
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned IdxW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic [CntW-1:0]         div_cnt_q, div_cnt_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [4*N_DIGITS-1:0]   snap_digits_q;
  logic [N_DIGITS-1:0]     snap_dp_q;
  logic                    snap_lz_q;
  logic [7:0]              seg_q, seg_d;
  logic [N_DIGITS-1:0]     dig_sel_q, dig_sel_d;
  logic                    frame_done_q, frame_done_d;

  logic                    slot_end, frame_wrap, blank;
  logic [N_DIGITS-1:0]     lead_zero;
  logic                    zero_run;

  function automatic logic [6:0] decode(input logic [3:0] code);
    case (code)
      4'h0:    decode = 7'h3F;
      4'h1:    decode = 7'h06;
      4'h2:    decode = 7'h5B;
      4'h3:    decode = 7'h4F;
      4'h4:    decode = 7'h66;
      4'h5:    decode = 7'h6D;
      4'h6:    decode = 7'h7D;
      4'h7:    decode = 7'h07;
      4'h8:    decode = 7'h7F;
      4'h9:    decode = 7'h6F;
      4'hA:    decode = HEX_EN ? 7'h77 : 7'h00;
      4'hB:    decode = HEX_EN ? 7'h7C : 7'h00;
      4'hC:    decode = HEX_EN ? 7'h39 : 7'h00;
      4'hD:    decode = HEX_EN ? 7'h5E : 7'h00;
      4'hE:    decode = HEX_EN ? 7'h79 : 7'h00;
      default: decode = HEX_EN ? 7'h71 : 7'h00;
    endcase
  endfunction

  assign slot_end   = bus.en && (div_cnt_q == CntW'(CLK_DIV - 1));
  assign frame_wrap = slot_end && (idx_q == IdxW'(N_DIGITS - 1));
  assign blank      = (32'(div_cnt_q) < BLANK_CYCLES);

  always_comb begin
    div_cnt_d = div_cnt_q;
    idx_d     = idx_q;
    if (bus.en) begin
      if (slot_end) begin
        div_cnt_d = '0;
        idx_d     = frame_wrap ? '0 : idx_q + 1'b1;
      end else begin
        div_cnt_d = div_cnt_q + 1'b1;
      end
    end
  end

  // lead_zero[k] is set when digits N_DIGITS-1 down to k are all zero.
  always_comb begin
    lead_zero = '0;
    zero_run  = 1'b1;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      zero_run     = zero_run && (snap_digits_q[4*k +: 4] == 4'h0);
      lead_zero[k] = zero_run;
    end
  end

  always_comb begin
    seg_d        = 8'h00;
    dig_sel_d    = '1;
    frame_done_d = frame_wrap;
    if (bus.en && !blank) begin
      for (int unsigned k = 0; k < N_DIGITS; k++) begin
        if (idx_q == IdxW'(k)) begin
          dig_sel_d[k] = 1'b0;
          seg_d[7]     = snap_dp_q[k];
          seg_d[6:0]   = (snap_lz_q && (k != 0) && lead_zero[k]) ? 7'h00
                                                                 : decode(snap_digits_q[4*k +: 4]);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q     <= '0;
      idx_q         <= '0;
      snap_digits_q <= '0;
      snap_dp_q     <= '0;
      snap_lz_q     <= 1'b0;
      seg_q         <= 8'h00;
      dig_sel_q     <= '1;
      frame_done_q  <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      idx_q        <= idx_d;
      seg_q        <= seg_d;
      dig_sel_q    <= dig_sel_d;
      frame_done_q <= frame_done_d;
      if (frame_wrap) begin
        snap_digits_q <= bus.digits_in;
        snap_dp_q     <= bus.dp_in;
        snap_lz_q     <= bus.lz_en;
      end
    end
  end

  assign bus.seg_out    = seg_q;
  assign bus.dig_sel    = dig_sel_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_scan_display_driver.sv
// Drives a hex and a non-hex instance with identical stimulus and compares both
// against a frame-position reference model.
module tb_scan_display_driver;

  localparam int N  = 4;
  localparam int CD = 4;
  localparam int BL = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic        lz;

  int checks = 0;
  int errors = 0;

  // Model state: position within the frame in enabled cycles, plus the snapshot.
  int          pos;
  logic [15:0] m_digits;
  logic [3:0]  m_dp;
  logic        m_lz;
  logic [7:0]  exp_seg_h, exp_seg_n;
  logic [3:0]  exp_sel;
  logic        exp_fd;

  localparam logic [6:0] PAT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  scan_display_driver_if #(.N_DIGITS(N)) bus_hex ();
  scan_display_driver_if #(.N_DIGITS(N)) bus_nohex ();

  assign bus_hex.en          = en;
  assign bus_hex.digits_in   = digits;
  assign bus_hex.dp_in       = dp;
  assign bus_hex.lz_en       = lz;
  assign bus_nohex.en        = en;
  assign bus_nohex.digits_in = digits;
  assign bus_nohex.dp_in     = dp;
  assign bus_nohex.lz_en     = lz;

  scan_display_driver #(.N_DIGITS(N), .CLK_DIV(CD), .BLANK_CYCLES(BL), .HEX_EN(1'b1)) u_dut_hex (
    .clk (clk),
    .rst (rst),
    .bus (bus_hex)
  );

  scan_display_driver #(.N_DIGITS(N), .CLK_DIV(CD), .BLANK_CYCLES(BL), .HEX_EN(1'b0)) u_dut_nohex (
    .clk (clk),
    .rst (rst),
    .bus (bus_nohex)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic check_all();
    check("seg_hex",   16'(bus_hex.seg_out),      16'(exp_seg_h));
    check("seg_nohex", 16'(bus_nohex.seg_out),    16'(exp_seg_n));
    check("sel_hex",   16'(bus_hex.dig_sel),      16'(exp_sel));
    check("sel_nohex", 16'(bus_nohex.dig_sel),    16'(exp_sel));
    check("fd_hex",    16'(bus_hex.frame_done),   16'(exp_fd));
    check("fd_nohex",  16'(bus_nohex.frame_done), 16'(exp_fd));
  endtask

  function automatic logic [6:0] pattern(input int code, input bit hex);
    if (!hex && code >= 10) return 7'h00;
    return PAT[code];
  endfunction

  task automatic model_reset();
    pos       = 0;
    m_digits  = '0;
    m_dp      = '0;
    m_lz      = 1'b0;
    exp_seg_h = 8'h00;
    exp_seg_n = 8'h00;
    exp_sel   = 4'hF;
    exp_fd    = 1'b0;
  endtask

  // Predicts the outputs after the coming edge from the pre-edge frame position.
  task automatic model_step();
    int  k, code;
    bit  supp;
    exp_seg_h = 8'h00;
    exp_seg_n = 8'h00;
    exp_sel   = 4'hF;
    exp_fd    = 1'b0;
    if (en && (pos % CD) >= BL) begin
      k         = pos / CD;
      code      = int'((m_digits >> (4*k)) & 16'hF);
      supp      = m_lz && (k > 0) && ((m_digits >> (4*k)) == 16'h0);
      exp_sel   = ~(4'b0001 << k);
      exp_seg_h = {m_dp[k], supp ? 7'h00 : pattern(code, 1'b1)};
      exp_seg_n = {m_dp[k], supp ? 7'h00 : pattern(code, 1'b0)};
    end
    if (en) begin
      if (pos == N*CD - 1) begin
        exp_fd   = 1'b1;
        pos      = 0;
        m_digits = digits;
        m_dp     = dp;
        m_lz     = lz;
      end else begin
        pos++;
      end
    end
  endtask

  task automatic cycle(input int n);
    for (int i = 0; i < n; i++) begin
      model_step();
      @(posedge clk);
      @(negedge clk);
      check_all();
    end
  endtask

  // Called at a falling edge: asserts reset mid-low-phase and checks the async clear.
  task automatic pulse_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
    check_all();
  endtask

  initial begin
    en     = 1'b1;
    digits = 16'h1234;
    dp     = 4'b0100;
    lz     = 1'b0;
    model_reset();
    @(negedge clk);
    check_all();
    rst = 1'b0;

    // Zero snapshot frame, then scan order of 1234 with dp on digit 2.
    cycle(3 * N * CD);

    digits = 16'h0050;
    lz     = 1'b1;
    cycle(2 * N * CD);
    lz = 1'b0;
    cycle(2 * N * CD);

    digits = 16'hAF0F;
    dp     = 4'b1001;
    cycle(2 * N * CD);

    // Mid-frame change must not tear the frame in progress.
    digits = 16'h1111;
    dp     = 4'b0000;
    cycle(N * CD + 6);
    digits = 16'h2222;
    cycle(2 * N * CD);

    // Freeze during slot 2, then reset during slot 3.
    for (int i = 0; i < 2 * N * CD && !(pos == 2 * CD + 2); i++) cycle(1);
    check("reach_slot2", 16'(pos), 16'(2 * CD + 2));
    en = 1'b0;
    cycle(5);
    en = 1'b1;
    for (int i = 0; i < 2 * N * CD && (pos / CD) != 3; i++) cycle(1);
    check("reach_slot3", 16'(pos / CD), 16'd3);
    pulse_reset();
    cycle(2 * N * CD);

    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 11) == 0) digits = 16'($urandom);
      if ($urandom_range(0, 11) == 0) digits = 16'($urandom) & 16'h00FF;
      if ($urandom_range(0, 15) == 0) dp = 4'($urandom);
      if ($urandom_range(0, 15) == 0) lz = 1'($urandom);
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 399) == 0) pulse_reset();
      cycle(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
